// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO drain-side stream reader: default data
// width, skid-buffer depth, pointer type and the mod-3 pointer increment.
package fifo_stream_reader_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int RD_BUF_DEPTH   = 3;
    localparam int RD_PTR_W       = 2;

    typedef logic [RD_PTR_W-1:0] rd_ptr_t;

    // Advance a buffer pointer, wrapping from the last entry back to 0.
    function automatic rd_ptr_t ptr_inc(input rd_ptr_t ptr);
        if (ptr == rd_ptr_t'(RD_BUF_DEPTH - 1)) begin
            return '0;
        end
        return rd_ptr_t'(ptr + 2'd1);
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry circular buffer that absorbs the FIFO read latency. One push
// and one pop may happen in the same cycle; the head entry is always
// presented on head_data.
module fifo_rd_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_reg [RD_BUF_DEPTH];
    rd_ptr_t          head_reg;
    rd_ptr_t          tail_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    // Storage is cleared on reset so the output word reads 0 afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[tail_reg] <= push_data;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            count_reg <= count_next;
        end
    end

    assign count     = count_reg;
    assign head_data = mem_reg[head_reg];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drain side of the synchronous FIFO: issues pops, captures the registered
// read data one cycle later into a small buffer and presents it as a
// valid/ready stream. r_en depends only on registered state plus
// enable/flag_empty, so m_ready never reaches the FIFO combinationally.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flag_empty,
    input  logic [FIFO_WIDTH-1:0] data_read,
    output logic                  r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  busy
);

    logic                 rd_pending_reg;
    logic [CNT_WIDTH-1:0] words_out_reg;
    logic [1:0]           buf_count;
    logic [2:0]           committed;
    logic                 handshake;

    // Slots already claimed: buffered words plus the read still in flight.
    // Pops stop once every slot is claimed, so the in-flight word always fits.
    assign committed = {1'b0, buf_count} + {2'b00, rd_pending_reg};
    assign r_en      = ~rst & enable & ~flag_empty
                       & (committed < 3'(RD_BUF_DEPTH));

    assign m_valid   = (buf_count != 2'd0);
    assign handshake = m_valid & m_ready;
    assign busy      = m_valid | rd_pending_reg;
    assign words_out = words_out_reg;

    // Track the pop issued last cycle; its data is on data_read now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending_reg <= 1'b0;
        end else begin
            rd_pending_reg <= r_en;
        end
    end

    // Count accepted output words, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_out_reg <= '0;
        end else if (handshake) begin
            words_out_reg <= words_out_reg + 1'b1;
        end
    end

    fifo_rd_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pending_reg),
        .push_data (data_read),
        .pop       (handshake),
        .count     (buf_count),
        .head_data (m_data)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural sync FIFO model
// (registered empty flag, one-cycle registered read data).
module tb_fifo_stream_reader;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flag_empty;
    logic [W-1:0]  data_read;
    logic          r_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [CW-1:0] words_out;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] fifo_q [$];
    logic [W-1:0] got_q  [$];
    int cyc, ren_cnt, ren_run, ren_max, vcnt, v_run, v_max;
    int first_ren, first_val;
    int bad_pop = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .flag_empty (flag_empty),
        .data_read  (data_read),
        .r_en       (r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .words_out  (words_out),
        .busy       (busy)
    );

    // Sync FIFO model: empty flag and read data both registered.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q.delete();
            flag_empty <= 1'b1;
            data_read  <= '0;
        end else begin
            if (r_en && !flag_empty && fifo_q.size() > 0) begin
                data_read <= fifo_q.pop_front();
            end
            flag_empty <= (fifo_q.size() == 0);
        end
    end

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (r_en) begin
                ren_cnt++;
                ren_run++;
                if (first_ren < 0) first_ren = cyc;
            end else begin
                ren_run = 0;
            end
            if (ren_run > ren_max) ren_max = ren_run;
            if (m_valid) begin
                vcnt++;
                v_run++;
                if (first_val < 0) first_val = cyc;
            end else begin
                v_run = 0;
            end
            if (v_run > v_max) v_max = v_run;
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (r_en && flag_empty) bad_pop++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_mon();
        cyc = 0; ren_cnt = 0; ren_run = 0; ren_max = 0;
        vcnt = 0; v_run = 0; v_max = 0;
        first_ren = -1; first_val = -1;
        got_q.delete();
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) fifo_q.push_back(W'(base + i));
    endtask

    task automatic chk_seq(input string tag, input int n, input int base);
        chk({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk({tag, "_data"}, got_q[i], base + i);
        end
    endtask

    task automatic reset_dut();
        enable = 1'b0; m_ready = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        clear_mon();
        step(2);
        // Reset state
        chk("rst_r_en", r_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_words_out", words_out, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step(1);

        // Single word with 2-cycle latency
        load(1, 8'hA5);
        enable = 1'b1; m_ready = 1'b1;
        clear_mon();
        step(6);
        $display("single: pops=%0d words=%0d", ren_cnt, got_q.size());
        chk("single_pops", ren_cnt, 1);
        chk_seq("single", 1, 8'hA5);
        chk("single_latency", first_val - first_ren, 2);
        chk("single_valid_len", v_max, 1);
        chk("single_words_out", words_out, 1);
        chk("single_busy", busy, 0);

        // Full-rate burst of 16; 4-bit counter wraps to 0
        reset_dut();
        load(16, 0);
        enable = 1'b1; m_ready = 1'b1;
        clear_mon();
        step(24);
        $display("burst: pops=%0d words=%0d", ren_cnt, got_q.size());
        chk("burst_pops", ren_cnt, 16);
        chk("burst_ren_run", ren_max, 16);
        chk("burst_valid_run", v_max, 16);
        chk_seq("burst", 16, 0);
        chk("burst_words_out_wrap", words_out, 0);

        // 17th word: counter reads 1
        clear_mon();
        load(1, 8'h10);
        step(6);
        $display("wrap: words=%0d words_out=%0d", got_q.size(), words_out);
        chk_seq("wrap", 1, 8'h10);
        chk("wrap_words_out", words_out, 1);

        // Reset with 2 buffered and 1 pending
        m_ready = 1'b0;
        load(16, 0);
        clear_mon();
        step(4);
        chk("midrst_pre_busy", busy, 1);
        chk("midrst_pre_valid", m_valid, 1);
        chk("midrst_pre_pops", ren_cnt, 3);
        rst = 1'b1;
        #1;
        $display("midrst: asserted");
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_r_en", r_en, 0);
        chk("midrst_words_out", words_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_m_data", m_data, 0);
        step(2);
        rst = 1'b0;
        clear_mon();
        step(6);
        chk("midrst_after_valid", vcnt, 0);
        chk("midrst_after_pops", ren_cnt, 0);

        // Backpressure: only 3 pops, head word held
        enable = 1'b1; m_ready = 1'b0;
        load(16, 0);
        clear_mon();
        step(10);
        $display("backpressure: pops=%0d m_data=%0h", ren_cnt, m_data);
        chk("bp_pops", ren_cnt, 3);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_m_data", m_data, 0);
        chk("bp_busy", busy, 1);
        step(1);
        chk("bp_m_data_stable", m_data, 0);
        chk("bp_no_accept", got_q.size(), 0);
        ren_max = 0;
        m_ready = 1'b1;
        step(25);
        $display("backpressure release: pops=%0d words=%0d", ren_cnt, got_q.size());
        chk("bp_resume_run", ren_max, 13);
        chk("bp_total_pops", ren_cnt, 16);
        chk_seq("bp", 16, 0);

        // Enable drop mid-burst
        reset_dut();
        load(16, 0);
        enable = 1'b1; m_ready = 1'b1;
        clear_mon();
        step(5);
        enable = 1'b0;
        chk("endrop_pops_at_drop", ren_cnt, 4);
        step(8);
        $display("enable drop: pops=%0d words=%0d", ren_cnt, got_q.size());
        chk("endrop_pops_held", ren_cnt, 4);
        chk_seq("endrop_drain", 4, 0);
        chk("endrop_busy", busy, 0);
        chk("endrop_m_valid", m_valid, 0);
        enable = 1'b1;
        step(20);
        $display("enable resume: pops=%0d words=%0d", ren_cnt, got_q.size());
        chk("endrop_total_pops", ren_cnt, 16);
        chk_seq("endrop_all", 16, 0);

        chk("no_pop_on_empty", bad_pop, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drain side of the team's synchronous FIFO.
- Issues pops on the FIFO read port (r_en / flag_empty / data_read) and absorbs the FIFO's 1-cycle registered read latency.
- Presents the data as a valid/ready stream with full throughput (1 word/clk) and no combinational path from m_ready to r_en.
- Sits between a sync FIFO instance and any valid/ready consumer.

Parameters:
- FIFO_WIDTH, 8, data word width; must match the attached FIFO.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- enable  input  1  permits new pops; 0 = stop issuing r_en (drain what is in flight)
- flag_empty  input  1  FIFO empty flag (registered in FIFO)
- data_read  input  FIFO_WIDTH  FIFO read data, valid the cycle after an r_en with flag_empty=0
- r_en  output  1  FIFO pop request
- m_valid  output  1  output word valid
- m_ready  input  1  consumer accepts
- m_data  output  FIFO_WIDTH  output word
- words_out  output  CNT_WIDTH  count of accepted output words, wraps
- busy  output  1  words buffered or a read in flight

Behaviour:
- Reset values: r_en=0, m_valid=0, m_data=0, words_out=0, busy=0; internal buffer empty; rd_pending=0.
- Internal state:
  - 3-entry circular buffer with head/tail pointers (2 bits, wrap 2->0) and buf_count (0..3).
  - rd_pending flag: registered copy of the last issued pop.
- r_en = enable & ~flag_empty & ((buf_count + rd_pending) < 3). Only registered terms plus enable/flag_empty; r_en=0 while rst=1.
- rd_pending <= r_en each clk. Every pop is issued with flag_empty=0, so the FIFO always honours it.
- Capture: when rd_pending=1, write data_read at tail, tail++ (mod 3).
- Output:
  - m_valid = (buf_count != 0).
  - m_data = buffer[head].
  - Handshake when m_valid & m_ready: head++ (mod 3), words_out++ (mod 2^CNT_WIDTH).
- Simultaneous capture and handshake: buf_count unchanged. Capture only: +1. Handshake only: -1.
- Latency: word visible on m_data/m_valid 2 clks after the r_en cycle (FIFO register + buffer capture).
- Throughput: m_ready held 1 with a non-empty FIFO gives steady state buf_count=1, rd_pending=1, r_en=1 every cycle, m_valid=1 every cycle.
- Backpressure (m_ready=0): at most 3 words are buffered. r_en stops once buf_count + rd_pending = 3. The in-flight word always has a free slot, so no overflow and no data is dropped.
- m_data/m_valid hold stable while m_valid=1 and m_ready=0.
- m_ready while m_valid=0: ignored.
- enable falling mid-burst: no new r_en from the next evaluation. The pending read is still captured and all buffered words are still delivered.
- flag_empty rising: r_en drops the same cycle. The FIFO's registered flag reflects the previous cycle's pop, so no pop is ever requested on an empty FIFO.
- Reset mid-operation: buffer and pending read are discarded and all outputs return to reset values. The FIFO shares rst, so no word is lost against a non-reset FIFO.
- busy = (buf_count != 0) | rd_pending.

Decomposition:
- Shared package:
  - FIFO_WIDTH default.
  - localparam RD_BUF_DEPTH=3 and its 2-bit pointer width.
  - Pointer-increment-with-wrap function (mod 3).
- One sub-module, fifo_rd_buf: the 3-entry buffer (push/pop/count/head data).
- The top level holds r_en generation, rd_pending and words_out.

Test Plan:
- Single word: FIFO holds 0xA5, enable=1, m_ready=1 -> r_en high 1 cycle; m_valid=1 with m_data=0xA5 2 clks later for 1 cycle; words_out=1; busy returns 0.
- Full burst: FIFO preloaded with 16 words 0x00..0x0F, m_ready=1 -> r_en high 16 consecutive cycles; m_valid high 16 consecutive cycles, data in order; words_out=16.
- Backpressure: 16 words, m_ready=0 for 10 cycles -> exactly 3 pops issued, buf_count=3, m_data=0x00 stable. Then m_ready=1 -> remaining 13 pops resume with no gap; all 16 words delivered in order, no loss or duplication.
- Enable drop: burst running, enable=0 at cycle 5 -> no r_en after that cycle; words already popped (≤3 beyond delivered) still emerge. enable=1 -> the sequence continues from the next FIFO word.
- Reset mid-burst: assert rst with 2 words buffered and 1 pending -> m_valid=0, r_en=0, words_out=0, busy=0 immediately. After release with an empty FIFO, no spurious m_valid.
- Counter wrap: CNT_WIDTH=4, deliver 17 words -> words_out reads 0 after 16 handshakes and 1 after the 17th.
